// File: rtl/mmio_perf_counter_bank_if.sv
// Request/response bus for memory-mapped peripherals beside the LC-3b data port.
// The master drives the request side; the slave answers with sel/resp/rdata.
interface mmio_perf_counter_bank_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_sel;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_sel, mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_sel, mem_resp, mem_rdata
  );
endinterface

// File: rtl/mmio_perf_counter_bank.sv
// Bank of NUM_CNT memory-mapped performance counters with low/high snapshot reads,
// per-channel/global clear, freeze and sticky overflow. Define PERF_CNT_SAT_EN to saturate instead of wrap.
module mmio_perf_counter_bank #(
  parameter int          NUM_CNT   = 16,
  parameter int          CNT_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CNT-1:0]   inc,
  mmio_perf_counter_bank_if.slave bus
);

  localparam logic [15:0]          LAST_OFF  = 16'(4 * NUM_CNT + 1);
  localparam logic [13:0]          CTRL_WORD = 14'(NUM_CNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [15:0]          snap_q, snap_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 freeze_q, freeze_d;
  logic                 ovf_q, ovf_d;

  logic [15:0]          off;
  logic [13:0]          word;
  logic                 in_win;
  logic                 ctrl_hit;
  logic                 acc;
  logic [NUM_CNT-1:0]   clr;
  logic                 unused_wdata;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c);
`ifdef PERF_CNT_SAT_EN
    return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
`else
    return c + CNT_WIDTH'(1);
`endif
  endfunction

  function automatic logic [15:0] hi_half(input logic [CNT_WIDTH-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    return w[31:16];
  endfunction

  // Window decode; the window never wraps, so one subtraction and two compares suffice
  always_comb begin
    off      = bus.mem_address - BASE_ADDR;
    word     = off[15:2];
    in_win   = (bus.mem_address >= BASE_ADDR) && (off <= LAST_OFF);
    ctrl_hit = (word == CTRL_WORD);
  end

  assign bus.mem_sel   = in_win;
  assign bus.mem_resp  = (state_q == RESP);
  assign bus.mem_rdata = rdata_q;
  assign unused_wdata  = ^bus.mem_wdata[15:3];

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    rdata_d  = rdata_q;
    freeze_d = freeze_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    clr      = '0;
    acc      = (state_q == IDLE) && in_win && (bus.mem_read || bus.mem_write);

    case (state_q)
      IDLE:    if (acc) state_d = RESP;
      default: state_d = IDLE;
    endcase

    if (acc && bus.mem_write) begin
      if (ctrl_hit) begin
        freeze_d = bus.mem_wdata[0];
        if (bus.mem_wdata[1]) begin
          clr    = '1;
          ovf_d  = 1'b0;
          snap_d = '0;
        end
        if (bus.mem_wdata[2]) ovf_d = 1'b0;
      end else begin
        for (int i = 0; i < NUM_CNT; i++)
          if (word == 14'(i)) clr[i] = 1'b1;
      end
    end else if (acc) begin
      if (ctrl_hit) begin
        rdata_d = {14'b0, ovf_q, freeze_q};
      end else if (off[1]) begin
        rdata_d = snap_q;
      end else begin
        // Low-half read captures the high half so the following high read is coherent
        for (int i = 0; i < NUM_CNT; i++)
          if (word == 14'(i)) begin
            rdata_d = cnt_q[i][15:0];
            snap_d  = hi_half(cnt_q[i]);
          end
      end
    end

    for (int i = 0; i < NUM_CNT; i++) begin
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (!freeze_q && inc[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
        cnt_d[i] = bump(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '{default: '0};
      snap_q   <= '0;
      rdata_q  <= '0;
      freeze_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      rdata_q  <= rdata_d;
      freeze_q <= freeze_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
